// File: rtl/immediate_generator_if.sv
// Decode-stage immediate bus: instruction/select/enable in, decoded immediates out.
interface immediate_generator_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instruction;
    logic [1:0]      imm_sel;
    logic            en;
    logic [XLEN-1:0] immediate;
    logic [XLEN-1:0] immediate_q;
    logic            imm_valid_q;
    logic            is_jtype;

    // Control/decode side drives the instruction and select.
    modport master (
        output instruction,
        output imm_sel,
        output en,
        input  immediate,
        input  immediate_q,
        input  imm_valid_q,
        input  is_jtype
    );

    // The immediate generator itself.
    modport slave (
        input  instruction,
        input  imm_sel,
        input  en,
        output immediate,
        output immediate_q,
        output imm_valid_q,
        output is_jtype
    );
endinterface

// File: rtl/immediate_generator.sv
// RV32I immediate generator: combinational decode of the I/S/B/U/J immediate
// selected by the control unit, plus a registered copy with a one-cycle valid.
module immediate_generator #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    immediate_generator_if.slave bus
);
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [1:0] SEL_I  = 2'b00;
    localparam logic [1:0] SEL_S  = 2'b01;
    localparam logic [1:0] SEL_B  = 2'b10;

    logic [31:0]     inst;
    logic            is_jal;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] immediate_next;
    logic            is_jtype_next;
    logic [XLEN-1:0] immediate_reg;
    logic            imm_valid_reg;

    assign inst   = bus.instruction;
    // Opcode only matters to split U from J when the select is 11.
    assign is_jal = (inst[6:0] == OPC_JAL);

    // All five candidate immediates, each sign-extended from inst[31].
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};

    // Format select; every select value produces a defined immediate.
    always_comb begin
        immediate_next = '0;
        is_jtype_next  = 1'b0;
        case (bus.imm_sel)
            SEL_I:   immediate_next = imm_i;
            SEL_S:   immediate_next = imm_s;
            SEL_B:   immediate_next = imm_b;
            default: begin
                immediate_next = is_jal ? imm_j : imm_u;
                is_jtype_next  = is_jal;
            end
        endcase
    end

    // Registered copy for the next stage; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            immediate_reg <= '0;
            imm_valid_reg <= 1'b0;
        end else if (bus.en) begin
            immediate_reg <= immediate_next;
            imm_valid_reg <= 1'b1;
        end else begin
            imm_valid_reg <= 1'b0;
        end
    end

    assign bus.immediate   = immediate_next;
    assign bus.is_jtype    = is_jtype_next;
    assign bus.immediate_q = immediate_reg;
    assign bus.imm_valid_q = imm_valid_reg;
endmodule

// File: tb/tb_immediate_generator.sv
// Directed bench for immediate_generator: literal vectors plus an arithmetic
// reference model compared against the outputs on every falling edge.
module tb_immediate_generator;
    logic clk;
    logic rst;

    immediate_generator_if #(.XLEN(32)) bus ();

    immediate_generator #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic        checking   = 1'b0;
    logic        model_known = 1'b0;
    logic [31:0] model_q;
    logic        model_v;

    // Reference decode: rebuild the field value numerically, then subtract
    // 2^width when the sign bit is set.
    function automatic logic [31:0] model_imm(logic [31:0] w, logic [1:0] sel);
        longint v;
        longint width;
        v = 0;
        width = 32;
        case (sel)
            2'd0: begin
                v = longint'(w[31:20]);
                width = 12;
            end
            2'd1: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                width = 12;
            end
            2'd2: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                width = 13;
            end
            default: begin
                if (w[6:0] == 7'h6F) begin
                    v = longint'(w[31]) * (64'd1 << 20) + longint'(w[19:12]) * 4096
                      + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                    width = 21;
                end else begin
                    return w & 32'hFFFF_F000;
                end
            end
        endcase
        if (w[31]) v = v - (64'sd1 <<< width);
        return v[31:0];
    endfunction

    function automatic logic model_jt(logic [31:0] w, logic [1:0] sel);
        return (sel == 2'b11) && (w[6:0] == 7'h6F);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model of the registered stage, advanced on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            model_q     = 32'h0;
            model_v     = 1'b0;
            model_known = 1'b1;
        end else if (bus.en) begin
            model_q = model_imm(bus.instruction, bus.imm_sel);
            model_v = 1'b1;
        end else begin
            model_v = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("model_imm", bus.immediate, model_imm(bus.instruction, bus.imm_sel));
            chk("model_jt", {31'b0, bus.is_jtype}, {31'b0, model_jt(bus.instruction, bus.imm_sel)});
            if (model_known) begin
                chk("model_q", bus.immediate_q, model_q);
                chk("model_v", {31'b0, bus.imm_valid_q}, {31'b0, model_v});
            end
        end
    end

    task automatic drive(input logic [31:0] w, input logic [1:0] sel,
                         input logic e, input logic r);
        @(posedge clk);
        #1;
        bus.instruction = w;
        bus.imm_sel     = sel;
        bus.en          = e;
        rst             = r;
        @(negedge clk);
        #1;
        $display("vec inst=0x%08h sel=%0d en=%0b rst=%0b -> imm=0x%08h jt=%0b q=0x%08h v=%0b",
                 w, sel, e, r, bus.immediate, bus.is_jtype, bus.immediate_q, bus.imm_valid_q);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  sel;
        logic [31:0] imm;
        logic        jt;
        string       name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'h0080_0093, 2'd0, 32'h0000_0008, 1'b0, "i_addi8"};
        vecs[1]  = '{32'hFFF0_0093, 2'd0, 32'hFFFF_FFFF, 1'b0, "i_fff"};
        vecs[2]  = '{32'h0020_A423, 2'd1, 32'h0000_0008, 1'b0, "s_sw8"};
        vecs[3]  = '{32'hFE20_AE23, 2'd1, 32'hFFFF_FFFC, 1'b0, "s_swm4"};
        vecs[4]  = '{32'h0020_8463, 2'd2, 32'h0000_0008, 1'b0, "b_beq8"};
        vecs[5]  = '{32'hFE20_8EE3, 2'd2, 32'hFFFF_FFFC, 1'b0, "b_beqm4"};
        vecs[6]  = '{32'h8000_0063, 2'd2, 32'hFFFF_F000, 1'b0, "b_neg"};
        vecs[7]  = '{32'h0000_10B7, 2'd3, 32'h0000_1000, 1'b0, "u_lui1"};
        vecs[8]  = '{32'h0080_00EF, 2'd3, 32'h0000_0008, 1'b1, "j_jal8"};
        vecs[9]  = '{32'h0000_00EF, 2'd3, 32'h0000_0000, 1'b1, "j_jal0"};
        vecs[10] = '{32'h8000_00EF, 2'd3, 32'hFFF0_0000, 1'b1, "j_maxneg"};
        vecs[11] = '{32'h8000_00B7, 2'd3, 32'h8000_0000, 1'b0, "u_neg"};
        vecs[12] = '{32'h1234_5097, 2'd3, 32'h1234_5000, 1'b0, "u_auipc"};
        vecs[13] = '{32'h0080_00EF, 2'd0, 32'h0000_0008, 1'b0, "i_jalopc"};

        rst             = 1'b1;
        bus.instruction = 32'h0;
        bus.imm_sel     = 2'd0;
        bus.en          = 1'b0;
        checking        = 1'b1;

        // Reset held for two edges.
        drive(32'h0, 2'd0, 1'b0, 1'b1);
        drive(32'h0, 2'd0, 1'b0, 1'b1);
        chk("rst_q", bus.immediate_q, 32'h0);
        chk("rst_v", {31'b0, bus.imm_valid_q}, 32'h0);

        // Load addi 8, then hold with en low.
        drive(32'h0080_0093, 2'd0, 1'b1, 1'b0);
        chk("addi_comb", bus.immediate, 32'h8);
        drive(32'h0080_0093, 2'd0, 1'b0, 1'b0);
        chk("load_q", bus.immediate_q, 32'h8);
        chk("load_v", {31'b0, bus.imm_valid_q}, 32'h1);
        drive(32'hFFF0_0093, 2'd0, 1'b0, 1'b0);
        chk("hold_q", bus.immediate_q, 32'h8);
        chk("hold_v", {31'b0, bus.imm_valid_q}, 32'h0);

        // Directed decode table; also pins the model to hand values.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].inst, vecs[i].sel, i[0], 1'b0);
            chk({vecs[i].name, "_imm"}, bus.immediate, vecs[i].imm);
            chk({vecs[i].name, "_jt"}, {31'b0, bus.is_jtype}, {31'b0, vecs[i].jt});
            chk({vecs[i].name, "_pin"}, model_imm(vecs[i].inst, vecs[i].sel), vecs[i].imm);
        end

        // Reset beats enable on the same edge; combinational path unaffected.
        drive(32'hFFF0_0093, 2'd0, 1'b1, 1'b1);
        chk("prio_comb", bus.immediate, 32'hFFFF_FFFF);
        drive(32'hFFF0_0093, 2'd0, 1'b1, 1'b0);
        chk("prio_q", bus.immediate_q, 32'h0);
        chk("prio_v", {31'b0, bus.imm_valid_q}, 32'h0);
        drive(32'h0000_10B7, 2'd3, 1'b0, 1'b0);
        chk("post_q", bus.immediate_q, 32'hFFFF_FFFF);
        chk("post_v", {31'b0, bus.imm_valid_q}, 32'h1);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
